// File: rtl/wr_ctrl_flex_pkg.sv
// Shared sizing helpers and parameter legality rules for the user-to-AXI write controller.
package wr_ctrl_flex_pkg;

    function automatic int words_per_beat(input int axi_w, input int user_w);
        return axi_w / user_w;
    endfunction

    function automatic int bytes_per_beat(input int axi_w);
        return axi_w / 8;
    endfunction

    function automatic int beats_per_burst(input int wr_len, input int axi_w);
        return wr_len / (axi_w / 8);
    endfunction

    // Width able to hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int wr_len, input int user_w, input int axi_w,
                                     input int timeout);
        int b;
        if (user_w <= 0 || (user_w % 8) != 0) return 1'b0;
        if (axi_w < user_w || (axi_w % user_w) != 0) return 1'b0;
        if ((wr_len % (axi_w / 8)) != 0) return 1'b0;
        b = wr_len / (axi_w / 8);
        if (b < 1 || b > 256) return 1'b0;
        return (timeout >= 0);
    endfunction

endpackage

// File: rtl/wr_ctrl_flex_if.sv
// User-side word stream and AXI-side beat/command outputs of the write controller.
interface wr_ctrl_flex_if #(
    parameter int P_USER_DATA_WIDTH = 16,
    parameter int P_AXI_DATA_WIDTH  = 128,
    parameter int P_AXI_ADDR_WIDTH  = 32
);
    logic                            i_user_valid;
    logic [P_USER_DATA_WIDTH-1:0]    i_user_data;
    logic                            i_user_last;
    logic [P_AXI_ADDR_WIDTH-1:0]     i_user_baddr;
    logic [P_AXI_ADDR_WIDTH-1:0]     i_user_faddr;
    logic [P_AXI_DATA_WIDTH-1:0]     o_axi_u2a_data;
    logic [P_AXI_DATA_WIDTH/8-1:0]   o_axi_u2a_strb;
    logic                            o_axi_u2a_valid;
    logic                            o_axi_u2a_last;
    logic                            o_axi_wr_en;
    logic [P_AXI_ADDR_WIDTH-1:0]     o_axi_wr_addr;
    logic [7:0]                      o_axi_wr_length;
    logic                            o_wrap;

    modport master (
        output i_user_valid, i_user_data, i_user_last, i_user_baddr, i_user_faddr,
        input  o_axi_u2a_data, o_axi_u2a_strb, o_axi_u2a_valid, o_axi_u2a_last,
        input  o_axi_wr_en, o_axi_wr_addr, o_axi_wr_length, o_wrap
    );

    modport slave (
        input  i_user_valid, i_user_data, i_user_last, i_user_baddr, i_user_faddr,
        output o_axi_u2a_data, o_axi_u2a_strb, o_axi_u2a_valid, o_axi_u2a_last,
        output o_axi_wr_en, o_axi_wr_addr, o_axi_wr_length, o_wrap
    );
endinterface

// File: rtl/wr_ctrl_sync.sv
// Two-flop level synchroniser into i_user_clk; 2-cycle latency, no backpressure.
module wr_ctrl_sync (
    input  logic i_user_clk,
    input  logic r_user_rst,
    input  logic async_lvl,
    output logic sync_lvl
);
    logic [1:0] sync_ff;

    always_ff @(posedge i_user_clk or posedge r_user_rst) begin
        if (r_user_rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], async_lvl};
        end
    end

    assign sync_lvl = sync_ff[1];
endmodule

// File: rtl/wr_ctrl_flex.sv
// Packs user words into AXI beats and bursts, closing on last/timeout/full; word-to-beat latency 2 cycles.
// No backpressure: the AXI side must take every beat and command as issued.
module wr_ctrl_flex
    import wr_ctrl_flex_pkg::*;
#(
    parameter int P_WR_LENGTH       = 4096,
    parameter int P_USER_DATA_WIDTH = 16,
    parameter int P_AXI_DATA_WIDTH  = 128,
    parameter int P_AXI_ADDR_WIDTH  = 32,
    parameter int P_FLUSH_TIMEOUT   = 64
) (
    input  logic        i_user_clk,
    input  logic        r_user_rst,
    input  logic        i_ddr_init,
    wr_ctrl_flex_if.slave bus
);
    localparam int W   = words_per_beat(P_AXI_DATA_WIDTH, P_USER_DATA_WIDTH);
    localparam int B   = beats_per_burst(P_WR_LENGTH, P_AXI_DATA_WIDTH);
    localparam int BY  = bytes_per_beat(P_AXI_DATA_WIDTH);
    localparam int UW  = P_USER_DATA_WIDTH;
    localparam int UB  = P_USER_DATA_WIDTH / 8;
    localparam int DW  = P_AXI_DATA_WIDTH;
    localparam int AW  = P_AXI_ADDR_WIDTH;
    localparam int WCW = cnt_width(W);
    localparam int NCW = cnt_width(B + 1);
    localparam int TCW = cnt_width(P_FLUSH_TIMEOUT + 1);
    localparam logic [BY-1:0] WORD_STRB = BY'((1 << UB) - 1);

    if (!params_ok(P_WR_LENGTH, P_USER_DATA_WIDTH, P_AXI_DATA_WIDTH, P_FLUSH_TIMEOUT)) begin : g_param_err
        $error("wr_ctrl_flex: illegal parameter combination");
    end

    logic            init_s;
    logic            in_vld, in_last;
    logic [UW-1:0]   in_dat;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [DW-1:0]   acc_dat_q, acc_dat_d, merged_dat, beat_dat;
    logic [BY-1:0]   acc_strb_q, acc_strb_d, merged_strb, beat_strb;
    logic [NCW-1:0]  n_q, n_d, beats_q;
    logic [TCW-1:0]  idle_q, idle_d;
    logic            pending, timeout_hit, word_full, beat, close;
    logic [AW-1:0]   addr_q, addr_nxt, addr_cur;
    logic [AW+1:0]   nxt_sum, nxt_lim;
    logic            wrap_c, upd_q;
    logic [DW-1:0]   dat_q;
    logic [BY-1:0]   strb_q;
    logic            vld_q, last_q, wr_en_q, wrap_q;
    logic [AW-1:0]   wr_addr_q;
    logic [7:0]      wr_len_q;

    wr_ctrl_sync u_init_sync (
        .i_user_clk (i_user_clk),
        .r_user_rst (r_user_rst),
        .async_lvl  (i_ddr_init),
        .sync_lvl   (init_s)
    );

    always_comb begin
        merged_dat  = acc_dat_q | (DW'(in_dat) << (int'(wcnt_q) * UW));
        merged_strb = acc_strb_q | (WORD_STRB << (int'(wcnt_q) * UB));
        pending     = (wcnt_q != '0) || (n_q != '0);
        word_full   = (wcnt_q == WCW'(W - 1));
        timeout_hit = (P_FLUSH_TIMEOUT != 0) && !in_vld && pending &&
                      (idle_q == TCW'(P_FLUSH_TIMEOUT - 1));

        beat       = 1'b0;
        close      = 1'b0;
        beat_dat   = merged_dat;
        beat_strb  = merged_strb;
        wcnt_d     = wcnt_q;
        acc_dat_d  = acc_dat_q;
        acc_strb_d = acc_strb_q;
        idle_d     = '0;
        n_d        = n_q;

        if (in_vld) begin
            // A word always wins over a coincident timeout, so idle simply restarts.
            if (word_full || in_last) begin
                beat       = 1'b1;
                close      = in_last || (n_q == NCW'(B - 1));
                wcnt_d     = '0;
                acc_dat_d  = '0;
                acc_strb_d = '0;
            end else begin
                wcnt_d     = wcnt_q + WCW'(1);
                acc_dat_d  = merged_dat;
                acc_strb_d = merged_strb;
            end
        end else if (timeout_hit) begin
            // With no words pending the accumulator is all zero: that is the padding beat.
            beat       = 1'b1;
            close      = 1'b1;
            beat_dat   = acc_dat_q;
            beat_strb  = acc_strb_q;
            wcnt_d     = '0;
            acc_dat_d  = '0;
            acc_strb_d = '0;
        end else if (pending && (P_FLUSH_TIMEOUT != 0)) begin
            idle_d = idle_q + TCW'(1);
        end

        if (beat) begin
            n_d = close ? '0 : n_q + NCW'(1);
        end
    end

    // Ring advance for the burst closed last cycle; bypassed if another closes right away.
    always_comb begin
        nxt_sum  = {2'b00, addr_q} + (AW+2)'(beats_q) * (AW+2)'(BY);
        nxt_lim  = nxt_sum + (AW+2)'(P_WR_LENGTH - 1);
        wrap_c   = nxt_lim > {2'b00, bus.i_user_faddr};
        addr_nxt = wrap_c ? bus.i_user_baddr : nxt_sum[AW-1:0];
        addr_cur = upd_q ? addr_nxt : addr_q;
    end

    always_ff @(posedge i_user_clk or posedge r_user_rst) begin
        if (r_user_rst) begin
            in_vld     <= 1'b0;
            in_dat     <= '0;
            in_last    <= 1'b0;
            wcnt_q     <= '0;
            acc_dat_q  <= '0;
            acc_strb_q <= '0;
            n_q        <= '0;
            idle_q     <= '0;
            addr_q     <= bus.i_user_baddr;
            upd_q      <= 1'b0;
            beats_q    <= '0;
            dat_q      <= '0;
            strb_q     <= '0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= bus.i_user_baddr;
            wr_len_q   <= '0;
            wrap_q     <= 1'b0;
        end else begin
            in_vld     <= bus.i_user_valid & init_s;
            in_dat     <= bus.i_user_data;
            in_last    <= bus.i_user_last & bus.i_user_valid & init_s;
            wcnt_q     <= wcnt_d;
            acc_dat_q  <= acc_dat_d;
            acc_strb_q <= acc_strb_d;
            n_q        <= n_d;
            idle_q     <= idle_d;
            vld_q      <= beat;
            last_q     <= close;
            wr_en_q    <= close;
            upd_q      <= close;
            wrap_q     <= upd_q & wrap_c;
            if (beat) begin
                dat_q  <= beat_dat;
                strb_q <= beat_strb;
            end
            if (close) begin
                wr_addr_q <= addr_cur;
                wr_len_q  <= 8'(n_q);
                beats_q   <= n_q + NCW'(1);
            end
            if (upd_q) begin
                addr_q <= addr_nxt;
            end
        end
    end

    assign bus.o_axi_u2a_data  = dat_q;
    assign bus.o_axi_u2a_strb  = strb_q;
    assign bus.o_axi_u2a_valid = vld_q;
    assign bus.o_axi_u2a_last  = last_q;
    assign bus.o_axi_wr_en     = wr_en_q;
    assign bus.o_axi_wr_addr   = wr_addr_q;
    assign bus.o_axi_wr_length = wr_len_q;
    assign bus.o_wrap          = wrap_q;
endmodule

// File: tb/tb_wr_ctrl_flex.sv
// Directed bench for wr_ctrl_flex: init gating, full/early/timeout bursts, padding, wrap and reset.
module tb_wr_ctrl_flex;
    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ddr_init = 1'b0;
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   put_cyc  = 0;

    wr_ctrl_flex_if #(.P_USER_DATA_WIDTH(16), .P_AXI_DATA_WIDTH(128), .P_AXI_ADDR_WIDTH(32)) bus ();

    wr_ctrl_flex #(
        .P_WR_LENGTH(4096), .P_USER_DATA_WIDTH(16), .P_AXI_DATA_WIDTH(128),
        .P_AXI_ADDR_WIDTH(32), .P_FLUSH_TIMEOUT(64)
    ) dut (
        .i_user_clk (clk),
        .r_user_rst (rst),
        .i_ddr_init (ddr_init),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] b_dat[$];
    logic [15:0]  b_strb[$];
    logic         b_last[$];
    int           b_cyc[$];
    logic [31:0]  c_addr[$];
    logic [7:0]   c_len[$];
    logic         c_wl[$];
    int           c_cyc[$];
    int           w_cyc[$];

    always @(negedge clk) begin
        if (bus.o_axi_u2a_valid === 1'b1) begin
            b_dat.push_back(bus.o_axi_u2a_data);
            b_strb.push_back(bus.o_axi_u2a_strb);
            b_last.push_back(bus.o_axi_u2a_last);
            b_cyc.push_back(cyc);
        end
        if (bus.o_axi_wr_en === 1'b1) begin
            c_addr.push_back(bus.o_axi_wr_addr);
            c_len.push_back(bus.o_axi_wr_length);
            c_wl.push_back(bus.o_axi_u2a_valid & bus.o_axi_u2a_last);
            c_cyc.push_back(cyc);
        end
        if (bus.o_wrap === 1'b1) w_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] gd(input int i);
        return (b_dat.size() > i) ? b_dat[i] : 'x;
    endfunction
    function automatic logic [15:0] gs(input int i);
        return (b_strb.size() > i) ? b_strb[i] : 'x;
    endfunction
    function automatic logic gl(input int i);
        return (b_last.size() > i) ? b_last[i] : 1'bx;
    endfunction
    function automatic logic [31:0] gbc(input int i);
        return (b_cyc.size() > i) ? 32'(b_cyc[i]) : 'x;
    endfunction
    function automatic logic [31:0] ga(input int i);
        return (c_addr.size() > i) ? c_addr[i] : 'x;
    endfunction
    function automatic logic [7:0] gn(input int i);
        return (c_len.size() > i) ? c_len[i] : 'x;
    endfunction
    function automatic logic gw(input int i);
        return (c_wl.size() > i) ? c_wl[i] : 1'bx;
    endfunction
    function automatic logic [31:0] gcc(input int i);
        return (c_cyc.size() > i) ? 32'(c_cyc[i]) : 'x;
    endfunction
    function automatic logic [31:0] gwc(input int i);
        return (w_cyc.size() > i) ? 32'(w_cyc[i]) : 'x;
    endfunction

    function automatic int n_lasts();
        int n = 0;
        foreach (b_last[i]) if (b_last[i]) n++;
        return n;
    endfunction

    function automatic logic [127:0] pack_n(input logic [15:0] base, input int n);
        logic [127:0] v = '0;
        for (int k = 0; k < n; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    task automatic clear_mon();
        b_dat.delete(); b_strb.delete(); b_last.delete(); b_cyc.delete();
        c_addr.delete(); c_len.delete(); c_wl.delete(); c_cyc.delete(); w_cyc.delete();
    endtask

    task automatic put(input logic [15:0] d, input logic l);
        @(negedge clk);
        bus.i_user_valid = 1'b1;
        bus.i_user_data  = d;
        bus.i_user_last  = l;
        put_cyc          = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_user_valid = 1'b0;
            bus.i_user_last  = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag, input logic [31:0] baddr);
        check({tag, "_data"},  bus.o_axi_u2a_data, 128'h0);
        check({tag, "_strb"},  bus.o_axi_u2a_strb, 16'h0);
        check({tag, "_valid"}, bus.o_axi_u2a_valid, 1'b0);
        check({tag, "_last"},  bus.o_axi_u2a_last, 1'b0);
        check({tag, "_wr_en"}, bus.o_axi_wr_en, 1'b0);
        check({tag, "_addr"},  bus.o_axi_wr_addr, baddr);
        check({tag, "_len"},   bus.o_axi_wr_length, 8'h0);
        check({tag, "_wrap"},  bus.o_wrap, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c7, cl;
        bus.i_user_valid = 1'b0;
        bus.i_user_data  = '0;
        bus.i_user_last  = 1'b0;
        bus.i_user_baddr = 32'h0001_0000;
        bus.i_user_faddr = 32'h0001_FFFF;

        repeat (3) @(negedge clk);
        check_reset_state("rst0", 32'h0001_0000);
        rst = 1'b0;

        // Words while DDR init is low must vanish.
        clear_mon();
        for (int i = 0; i < 20; i++) put(16'h5000 + 16'(i), i == 9);
        idle(6);
        check("gate_nbeats", b_dat.size(), 0);
        check("gate_ncmds", c_addr.size(), 0);

        // Init rises with word 0; the synchroniser makes word 2 the first one packed.
        clear_mon();
        put(16'hA000, 1'b0);
        ddr_init = 1'b1;
        for (int i = 1; i < 10; i++) put(16'hA000 + 16'(i), i == 9);
        idle(5);
        check("init_nbeats", b_dat.size(), 1);
        check("init_data", gd(0), pack_n(16'hA002, 8));
        check("init_last", gl(0), 1'b1);
        check("init_addr", ga(0), 32'h0001_0000);
        check("init_len", gn(0), 8'd0);

        // Full burst: 2048 words -> 256 beats, one command.
        clear_mon();
        c7 = 0;
        for (int i = 0; i < 2048; i++) begin
            put(16'(i), 1'b0);
            if (i == 7) c7 = put_cyc;
        end
        idle(5);
        check("fb_nbeats", b_dat.size(), 256);
        check("fb_b0_data", gd(0), pack_n(16'h0000, 8));
        check("fb_b0_strb", gs(0), 16'hFFFF);
        check("fb_latency", gbc(0), 32'(c7 + 2));
        check("fb_b100_data", gd(100), pack_n(16'd800, 8));
        check("fb_b255_data", gd(255), pack_n(16'd2040, 8));
        check("fb_b255_last", gl(255), 1'b1);
        check("fb_nlasts", n_lasts(), 1);
        check("fb_ncmds", c_addr.size(), 1);
        check("fb_addr", ga(0), 32'h0001_0010);
        check("fb_len", gn(0), 8'd255);
        check("fb_cmd_with_last", gw(0), 1'b1);

        // Early last on word 13: full beat then 5-word partial beat.
        clear_mon();
        for (int i = 0; i < 13; i++) put(16'h0100 + 16'(i), i == 12);
        idle(5);
        check("el_nbeats", b_dat.size(), 2);
        check("el_b0_last", gl(0), 1'b0);
        check("el_b1_data", gd(1), pack_n(16'h0108, 5));
        check("el_b1_strb", gs(1), 16'h03FF);
        check("el_b1_last", gl(1), 1'b1);
        check("el_addr", ga(0), 32'h0001_1010);
        check("el_len", gn(0), 8'd1);

        // Last coinciding with a full beat: no padding.
        clear_mon();
        for (int i = 0; i < 16; i++) put(16'h0200 + 16'(i), i == 15);
        idle(5);
        check("lf_nbeats", b_dat.size(), 2);
        check("lf_b1_strb", gs(1), 16'hFFFF);
        check("lf_b1_last", gl(1), 1'b1);
        check("lf_addr", ga(0), 32'h0001_1030);
        check("lf_len", gn(0), 8'd1);

        // One full beat then silence: timeout closes with a zero padding beat.
        clear_mon();
        for (int i = 0; i < 8; i++) put(16'h0300 + 16'(i), 1'b0);
        cl = put_cyc;
        idle(70);
        check("pad_nbeats", b_dat.size(), 2);
        check("pad_b0_last", gl(0), 1'b0);
        check("pad_b1_data", gd(1), 128'h0);
        check("pad_b1_strb", gs(1), 16'h0000);
        check("pad_b1_last", gl(1), 1'b1);
        check("pad_b1_cycle", gbc(1), 32'(cl + 66));
        check("pad_addr", ga(0), 32'h0001_1050);
        check("pad_len", gn(0), 8'd1);

        // A word landing on the timeout cycle wins; the later timeout flushes 4 words.
        clear_mon();
        for (int i = 0; i < 3; i++) put(16'h0400 + 16'(i), 1'b0);
        idle(63);
        put(16'h0403, 1'b0);
        idle(80);
        check("race_nbeats", b_dat.size(), 1);
        check("race_data", gd(0), pack_n(16'h0400, 4));
        check("race_strb", gs(0), 16'h00FF);
        check("race_last", gl(0), 1'b1);
        check("race_addr", ga(0), 32'h0001_1070);
        check("race_len", gn(0), 8'd0);

        // Reset after 100 beats drops the burst; the next one starts fresh at base.
        clear_mon();
        for (int i = 0; i < 800; i++) put(16'(i), 1'b0);
        idle(3);
        check("mr_nbeats", b_dat.size(), 100);
        check("mr_ncmds", c_addr.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_state("mr", 32'h0001_0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);
        clear_mon();
        for (int i = 0; i < 2048; i++) put(16'(i), 1'b0);
        idle(5);
        check("mr_post_nbeats", b_dat.size(), 256);
        check("mr_post_ncmds", c_addr.size(), 1);
        check("mr_post_addr", ga(0), 32'h0001_0000);
        check("mr_post_len", gn(0), 8'd255);

        // Two-burst ring: third burst wraps back to base.
        @(negedge clk);
        rst = 1'b1;
        bus.i_user_baddr = 32'h0;
        bus.i_user_faddr = 32'd8191;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);
        clear_mon();
        for (int i = 0; i < 3 * 2048; i++) put(16'(i), 1'b0);
        idle(5);
        check("wr_ncmds", c_addr.size(), 3);
        check("wr_addr0", ga(0), 32'd0);
        check("wr_addr1", ga(1), 32'd4096);
        check("wr_addr2", ga(2), 32'd0);
        check("wr_nwraps", w_cyc.size(), 1);
        check("wr_wrap_cycle", gwc(0), gcc(1) + 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
